sc_nn_run_ctrl: RTL

Run controller for the stochastic-computing MNIST network (two layers of APC neurons). It accepts a start request and pulses the network's reset. It then enables the stochastic number generators for a configured bitstream length, waits out the network's pipeline latency, and counts the ones on every output bitstream. The final counts are returned through a valid/ready result port. It sits between the host/test harness and the `sc_mnist_nn` datapath plus its SNGs.

---
 rtl/sc_nn_ctrl_pkg.sv | 17 +
 rtl/sc_ones_counter.sv | 21 ++
 rtl/sc_nn_run_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sc_nn_ctrl_pkg.sv
// Shared types and helpers for the stochastic-computing network run controller.
package sc_nn_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } run_state_t;

    // A run of up to 2^len_w bits needs one extra bit to hold a full count.
    function automatic int cnt_w(input int len_w);
        return len_w + 1;
    endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Counts ones on a single output bitstream while the count window is open.
module sc_ones_counter #(
    parameter int CW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic          bit_in,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && bit_in) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/sc_nn_run_ctrl.sv
// Run controller: resets the network, enables the SNGs for a configured length,
// counts ones on each output bitstream after the pipeline latency and returns the counts.
module sc_nn_run_ctrl
    import sc_nn_ctrl_pkg::*;
#(
    parameter int N_OUT    = 1,
    parameter int LEN_W    = 8,
    parameter int CLR_CYC  = 1,
    parameter int PIPE_LAT = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start_valid,
    output logic                                start_ready,
    input  logic [LEN_W-1:0]                    cfg_len,
    input  logic                                abort,
    output logic                                nn_reset,
    output logic                                sng_en,
    input  logic [N_OUT-1:0]                    nn_dout,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [N_OUT*cnt_w(LEN_W)-1:0]       res_count,
    output logic                                busy
);

    localparam int CW    = cnt_w(LEN_W);
    localparam int CLR_W = $clog2(CLR_CYC + 1);
    localparam int LAT_W = $clog2(PIPE_LAT + 1);
    localparam int PH_A  = (CW > CLR_W) ? CW : CLR_W;
    localparam int PH_W  = (PH_A > LAT_W) ? PH_A : LAT_W;

    localparam logic [PH_W-1:0] PH_CLR   = PH_W'(CLR_CYC - 1);
    localparam logic [PH_W-1:0] PH_DRAIN = PH_W'(PIPE_LAT - 1);

    run_state_t       state;
    logic [PH_W-1:0]  ph;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] run_last;
    logic             in_run_phase;
    logic             clr_cnt;
    logic             cnt_en;

    // len_q==0 wraps to all-ones, i.e. 2^LEN_W-1, which is exactly the last index of a full-length run.
    assign run_last     = len_q - 1'b1;
    assign in_run_phase = (state == CLEAR) || (state == RUN) || (state == DRAIN);
    assign clr_cnt      = (state == IDLE) && start_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ph    <= '0;
            len_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_valid) begin
                        state <= CLEAR;
                        len_q <= cfg_len;
                        ph    <= PH_CLR;
                    end
                end
                CLEAR: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (ph == '0) begin
                        state <= RUN;
                        ph    <= {{(PH_W-LEN_W){1'b0}}, run_last};
                    end else begin
                        ph <= ph - 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (ph == '0) begin
                        if (PIPE_LAT == 0) begin
                            state <= DONE;
                        end else begin
                            state <= DRAIN;
                            ph    <= PH_DRAIN;
                        end
                    end else begin
                        ph <= ph - 1'b1;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (ph == '0) begin
                        state <= DONE;
                    end else begin
                        ph <= ph - 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign start_ready = (state == IDLE);
    assign sng_en      = (state == RUN);
    assign res_valid   = (state == DONE);
    assign busy        = (state != IDLE);
    assign nn_reset    = reset || (state == CLEAR);

    // Count enable follows sng_en by the network latency so each counted bit matches an enabled SNG cycle.
    generate
        if (PIPE_LAT == 0) begin : g_nodly
            assign cnt_en = sng_en;
        end else begin : g_dly
            logic [PIPE_LAT-1:0] en_p;
            always_ff @(posedge clk) begin
                if (reset || (abort && in_run_phase)) begin
                    en_p <= '0;
                end else begin
                    en_p[0] <= sng_en;
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        en_p[i] <= en_p[i-1];
                    end
                end
            end
            assign cnt_en = en_p[PIPE_LAT-1];
        end
    endgenerate

    generate
        for (genvar g = 0; g < N_OUT; g++) begin : g_cnt
            sc_ones_counter #(
                .CW(CW)
            ) u_cnt (
                .clk    (clk),
                .reset  (reset),
                .clr    (clr_cnt),
                .en     (cnt_en),
                .bit_in (nn_dout[g]),
                .count  (res_count[g*CW +: CW])
            );
        end
    endgenerate

endmodule
